// File: rtl/cordic_seq_pkg.sv
// Shared encodings for the CORDIC front-panel sequencer: FSM states,
// button bit positions and CORDIC mode values.
package cordic_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    START_P   = 3'd2,
    WAIT_DONE = 3'd3,
    SHOW      = 3'd4
  } state_e;

  localparam int BTN_LOAD  = 0;
  localparam int BTN_START = 1;
  localparam int BTN_MODE  = 2;
  localparam int BTN_SHOW  = 3;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

endpackage

// File: rtl/btn_edge_sync.sv
// Per-bit two-flop synchronizer followed by a rising-edge detector; turns
// raw debounced button levels into one-cycle press pulses.
module btn_edge_sync #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] level_i,
  output logic [N-1:0] pulse_o
);

  logic [N-1:0] meta_q, meta_d;
  logic [N-1:0] sync_q, sync_d;
  logic [N-1:0] prev_q, prev_d;

  always_comb begin
    meta_d = level_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/cordic_button_sequencer.sv
// Front-panel sequencer: latches a range-checked angle, starts the CORDIC
// core, waits for done with a timeout and steers X or Y to the display.
// Optional macro PRESS_SYNC_EN: synchronize and edge-detect raw button levels.
module cordic_button_sequencer
  import cordic_seq_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int MAX_ANGLE      = 12868,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       btn_press,
  input  logic [WIDTH-1:0] sw,
  input  logic             cordic_done,
  input  logic [WIDTH-1:0] cordic_x,
  input  logic [WIDTH-1:0] cordic_y,
  output logic             cordic_start,
  output logic [WIDTH-1:0] cordic_angle,
  output logic             cordic_mode,
  output logic [WIDTH-1:0] disp_value,
  output logic             disp_sel,
  output logic             busy,
  output logic             err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);
  localparam logic signed [WIDTH-1:0] MAX_S = WIDTH'(MAX_ANGLE);
  localparam logic signed [WIDTH-1:0] MIN_S = {1'b1, {(WIDTH-1){1'b0}}};

  // Negating the most negative code wraps to itself, so it is rejected first.
  function automatic logic in_range(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] neg;
    neg = -v;
    if (v == MIN_S)      return 1'b0;
    else if (v[WIDTH-1]) return neg <= MAX_S;
    else                 return v <= MAX_S;
  endfunction

  logic [3:0] press;

`ifdef PRESS_SYNC_EN
  btn_edge_sync #(.N(4)) u_btn_edge_sync (
    .clk     (clk),
    .reset   (reset),
    .level_i (btn_press),
    .pulse_o (press)
  );
`else
  assign press = btn_press;
`endif

  logic do_load, do_start, do_mode, do_show;
  assign do_load  = press[BTN_LOAD];
  assign do_start = press[BTN_START] & ~press[BTN_LOAD];
  assign do_mode  = press[BTN_MODE]  & ~press[BTN_LOAD] & ~press[BTN_START];
  assign do_show  = press[BTN_SHOW]  & ~press[BTN_LOAD] & ~press[BTN_START] & ~press[BTN_MODE];

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  angle_q, angle_d;
  logic              mode_q, mode_d;
  logic              err_q, err_d;
  logic              sel_q, sel_d;
  logic [WIDTH-1:0]  res_x_q, res_x_d;
  logic [WIDTH-1:0]  res_y_q, res_y_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    angle_d = angle_q;
    mode_d  = mode_q;
    err_d   = err_q;
    sel_d   = sel_q;
    res_x_d = res_x_q;
    res_y_d = res_y_q;
    cnt_d   = cnt_q;
    case (state_q)
      // Idle, armed and show share LOAD/MODE handling; START needs an operand.
      IDLE, ARMED, SHOW: begin
        if (do_load) begin
          if (in_range(sw)) begin
            angle_d = sw;
            err_d   = 1'b0;
            state_d = ARMED;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (do_start && state_q != IDLE) begin
          state_d = START_P;
        end else if (do_mode) begin
          mode_d = ~mode_q;
        end else if (do_show && state_q == SHOW) begin
          sel_d = ~sel_q;
        end
      end
      START_P: begin
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (cordic_done) begin
          res_x_d = cordic_x;
          res_y_d = cordic_y;
          sel_d   = 1'b0;
          state_d = SHOW;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      angle_q <= '0;
      mode_q  <= MODE_ROT;
      err_q   <= 1'b0;
      sel_q   <= 1'b0;
      res_x_q <= '0;
      res_y_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      angle_q <= angle_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      res_x_q <= res_x_d;
      res_y_q <= res_y_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cordic_start = (state_q == START_P);
  assign busy         = (state_q == START_P) || (state_q == WAIT_DONE);
  assign cordic_angle = angle_q;
  assign cordic_mode  = mode_q;
  assign err          = err_q;
  assign disp_sel     = sel_q;
  assign disp_value   = sel_q ? res_y_q : res_x_q;

endmodule

// File: tb/tb_cordic_button_sequencer.sv
// Self-checking bench for cordic_button_sequencer: a behavioural model
// checked every cycle plus directed scenarios with literal expectations.
module tb_cordic_button_sequencer;

  localparam int WIDTH   = 16;
  localparam int MAXA    = 12868;
  localparam int TIMEOUT = 64;
`ifdef PRESS_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       btn_press = 4'b0;
  logic [WIDTH-1:0] sw = '0;
  logic             cordic_done = 1'b0;
  logic [WIDTH-1:0] cordic_x = '0;
  logic [WIDTH-1:0] cordic_y = '0;
  logic             cordic_start;
  logic [WIDTH-1:0] cordic_angle;
  logic             cordic_mode;
  logic [WIDTH-1:0] disp_value;
  logic             disp_sel;
  logic             busy;
  logic             err;

  int n_checks = 0;
  int n_pass   = 0;
  logic cmp_en = 1'b0;

  cordic_button_sequencer #(
    .WIDTH(WIDTH), .MAX_ANGLE(MAXA), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .btn_press(btn_press), .sw(sw),
    .cordic_done(cordic_done), .cordic_x(cordic_x), .cordic_y(cordic_y),
    .cordic_start(cordic_start), .cordic_angle(cordic_angle),
    .cordic_mode(cordic_mode), .disp_value(disp_value), .disp_sel(disp_sel),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Behavioural model: operand held, run in progress, result shown.
  logic       m_ready = 0, m_showing = 0, m_pulse = 0, m_waiting = 0;
  int         m_waited = 0;
  int         m_angle = 0, m_rx = 0, m_ry = 0;
  logic       m_mode = 0, m_err = 0, m_sel = 0;
  logic [3:0] m_eff, m_s1 = 0, m_s2 = 0, m_s3 = 0;

  function automatic logic angle_ok(input logic [WIDTH-1:0] v);
    int a;
    a = int'($signed(v));
    return (a >= -MAXA) && (a <= MAXA);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ready = 0; m_showing = 0; m_pulse = 0; m_waiting = 0; m_waited = 0;
      m_angle = 0; m_rx = 0; m_ry = 0; m_mode = 0; m_err = 0; m_sel = 0;
      m_s1 = 0; m_s2 = 0; m_s3 = 0;
    end else begin
`ifdef PRESS_SYNC_EN
      m_eff = m_s2 & ~m_s3;
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = btn_press;
`else
      m_eff = btn_press;
`endif
      if (m_pulse) begin
        m_pulse = 0; m_waiting = 1; m_waited = 0;
      end else if (m_waiting) begin
        if (cordic_done) begin
          m_rx = int'($signed(cordic_x)); m_ry = int'($signed(cordic_y));
          m_sel = 0; m_waiting = 0; m_showing = 1;
        end else begin
          m_waited++;
          if (m_waited == TIMEOUT - 1) begin
            m_err = 1; m_waiting = 0; m_ready = 0; m_showing = 0;
          end
        end
      end else if (m_eff[0]) begin
        m_showing = 0;
        if (angle_ok(sw)) begin
          m_angle = int'($signed(sw)); m_err = 0; m_ready = 1;
        end else begin
          m_err = 1; m_ready = 0;
        end
      end else if (m_eff[1]) begin
        if (m_ready) begin m_pulse = 1; m_showing = 0; end
      end else if (m_eff[2]) begin
        m_mode = ~m_mode;
      end else if (m_eff[3]) begin
        if (m_showing) m_sel = ~m_sel;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("model_start", cordic_start, m_pulse);
      checkOutput("model_busy", busy, m_pulse | m_waiting);
      checkOutput("model_angle", $signed(cordic_angle), m_angle);
      checkOutput("model_mode", cordic_mode, m_mode);
      checkOutput("model_err", err, m_err);
      checkOutput("model_sel", disp_sel, m_sel);
      checkOutput("model_disp", $signed(disp_value), m_sel ? m_ry : m_rx);
    end
  end

  // Drives one press; returns once its effect is visible.
  task automatic applyStimulus(input logic [3:0] bits);
    btn_press = bits;
    @(posedge clk); #1;
    btn_press = 4'b0;
    repeat (EXTRA) begin @(posedge clk); #1; end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int n_busy, n_start, k_hit;

  initial begin
    $display("[TB] start, EXTRA=%0d", EXTRA);
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    checkOutput("reset_start", cordic_start, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_disp", disp_value, 0);
    checkOutput("reset_angle", cordic_angle, 0);
    reset = 1'b0;
    waitCycles(1);

    // Range checks
    sw = 16'(12869); applyStimulus(4'b0001);
    checkOutput("range_hi_err", err, 1);
    applyStimulus(4'b0010);
    checkOutput("range_hi_idle", busy, 0);
    sw = 16'(-12868); applyStimulus(4'b0001);
    checkOutput("range_neg_err", err, 0);
    checkOutput("range_neg_angle", $signed(cordic_angle), -12868);
    sw = 16'h8000; applyStimulus(4'b0001);
    checkOutput("range_min_err", err, 1);
    applyStimulus(4'b0010);
    checkOutput("range_min_idle", cordic_start, 0);

    // Normal rotation run, with MODE pressed during the wait
    sw = 16'(8192); applyStimulus(4'b0001);
    checkOutput("run_angle", $signed(cordic_angle), 8192);
    checkOutput("run_err", err, 0);
    applyStimulus(4'b0010);
    checkOutput("run_start", cordic_start, 1);
    n_busy = busy ? 1 : 0;
    n_start = cordic_start ? 1 : 0;
    cordic_x = 16'(6640); cordic_y = 16'(6891);
    for (int i = 1; i <= 21; i++) begin
      @(posedge clk); #1;
      cordic_done = (i == 20);
      btn_press = (i == 5) ? 4'b0100 : 4'b0000;
      if (busy) n_busy++;
      if (cordic_start) n_start++;
    end
    checkOutput("run_busy_cycles", n_busy, 21);
    checkOutput("run_start_cycles", n_start, 1);
    checkOutput("run_disp_x", $signed(disp_value), 6640);
    checkOutput("run_sel_x", disp_sel, 0);
    checkOutput("run_mode_frozen", cordic_mode, 0);
    applyStimulus(4'b1000);
    checkOutput("run_disp_y", $signed(disp_value), 6891);
    checkOutput("run_sel_y", disp_sel, 1);

    // MODE in SHOW then START re-runs in vectoring mode
    applyStimulus(4'b0100);
    checkOutput("rerun_mode", cordic_mode, 1);
    applyStimulus(4'b0010);
    checkOutput("rerun_start", cordic_start, 1);
    cordic_x = 16'(100); cordic_y = 16'(-200);
    waitCycles(2);
    cordic_done = 1'b1;
    waitCycles(1);
    cordic_done = 1'b0;
    waitCycles(1);
    checkOutput("rerun_disp", $signed(disp_value), 100);
    checkOutput("rerun_angle", $signed(cordic_angle), 8192);

    // LOAD beats START
    sw = 16'(300); applyStimulus(4'b0001);
    sw = 16'(500); applyStimulus(4'b0011);
    checkOutput("prio_angle", $signed(cordic_angle), 500);
    checkOutput("prio_nostart", cordic_start, 0);
    checkOutput("prio_busy", busy, 0);

    // Timeout
    sw = 16'(100); applyStimulus(4'b0001);
    applyStimulus(4'b0010);
    k_hit = TIMEOUT + 20;
    for (int k = 1; k <= TIMEOUT + 16; k++) begin
      @(posedge clk); #1;
      if (err) begin k_hit = k; break; end
    end
    checkOutput("timeout_latency", k_hit, TIMEOUT);
    checkOutput("timeout_busy", busy, 0);
    checkOutput("timeout_disp", $signed(disp_value), 100);
    applyStimulus(4'b0010);
    checkOutput("timeout_idle", cordic_start, 0);

    // Reset in the middle of WAIT_DONE, late done ignored
    sw = 16'(8192); applyStimulus(4'b0001);
    applyStimulus(4'b0010);
    waitCycles(5);
    #1 reset = 1'b1;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_disp", disp_value, 0);
    checkOutput("rst_angle", cordic_angle, 0);
    @(posedge clk); #1 reset = 1'b0;
    cordic_x = 16'(555); cordic_y = 16'(777);
    waitCycles(4);
    cordic_done = 1'b1;
    waitCycles(1);
    cordic_done = 1'b0;
    waitCycles(1);
    checkOutput("late_done_disp", disp_value, 0);
    checkOutput("late_done_busy", busy, 0);
    applyStimulus(4'b0010);
    checkOutput("late_done_idle", cordic_start, 0);

`ifdef PRESS_SYNC_EN
    // Held START level produces exactly one start pulse
    sw = 16'(200); applyStimulus(4'b0001);
    btn_press = 4'b0010;
    n_start = 0; k_hit = 0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (k == 10) btn_press = 4'b0000;
      if (cordic_start) begin
        n_start++;
        if (k_hit == 0) k_hit = k;
      end
    end
    checkOutput("sync_start_count", n_start, 1);
    checkOutput("sync_start_latency", k_hit, 3);
    waitCycles(TIMEOUT + 4);
    checkOutput("sync_timeout_err", err, 1);
`endif

    waitCycles(2);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cordic_button_sequencer.md
Name: cordic_button_sequencer

Overview:
Front-panel controller that turns debounced push-button press pulses and slide-switch operands into CORDIC operations.
- Latches the operand angle and selects rotation or vectoring mode.
- Issues a single-cycle start pulse to the CORDIC core and waits for done, with a timeout.
- Captures the X/Y results and steers one of them to the display.
- Sits between the per-button debouncers and the CORDIC datapath / display driver.

Parameters:
- WIDTH, 16: operand/result width, signed Q3.13.
- MAX_ANGLE, 12868: largest accepted |angle| (pi/2 in Q3.13).
- TIMEOUT_CYCLES, 64: cycles allowed between start and done before error.

Ports:
- clk  in  1  system clock, all logic posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- btn_press  in  4  press pulses, one cycle each. Bit 0 LOAD, bit 1 START, bit 2 MODE, bit 3 SHOW.
- sw  in  WIDTH  signed angle operand from switches.
- cordic_done  in  1  one-cycle completion pulse from core.
- cordic_x  in  WIDTH  core X result, valid when cordic_done=1.
- cordic_y  in  WIDTH  core Y result, valid when cordic_done=1.
- cordic_start  out  1  one-cycle start pulse.
- cordic_angle  out  WIDTH  registered operand to core.
- cordic_mode  out  1  0 rotation, 1 vectoring.
- disp_value  out  WIDTH  value for display.
- disp_sel  out  1  0 shows X, 1 shows Y.
- busy  out  1  high in START_P and WAIT_DONE.
- err  out  1  sticky error flag; cleared by the next accepted LOAD.

Behaviour:
- Reset is asynchronous, active-high. Clock is clk.
- Reset values: state IDLE; all outputs 0; timeout counter 0.
- Button priority when several bits are high in one cycle: LOAD > START > MODE > SHOW. Only the winner acts; the others are dropped, not queued.
- IDLE:
  - LOAD with |sw| <= MAX_ANGLE: cordic_angle <= sw next cycle, err <= 0, go ARMED.
  - LOAD with |sw| > MAX_ANGLE: err <= 1, stay IDLE.
  - MODE toggles cordic_mode.
  - START and SHOW are ignored.
- ARMED:
  - LOAD re-latches the operand with the same range check. An out-of-range value sets err and goes to IDLE.
  - MODE toggles cordic_mode.
  - START goes to START_P.
- START_P: cordic_start=1 for exactly this one cycle; counter <= 0; go WAIT_DONE. Latency from START press to cordic_start is 1 cycle.
- WAIT_DONE:
  - All buttons are ignored, and cordic_angle and cordic_mode are frozen.
  - cordic_done=1: capture x/y into result registers, disp_sel <= 0, go SHOW. disp_value shows X on the following cycle.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 without done: err <= 1, go IDLE, results unchanged.
  - If done and the timeout coincide, done wins.
- SHOW:
  - SHOW toggles disp_sel; disp_value follows in the same cycle from the captured registers.
  - START re-runs with the same operand (go START_P).
  - LOAD behaves as in ARMED.
  - MODE toggles cordic_mode; it takes effect on the next START.
- cordic_done outside WAIT_DONE is ignored.
- Range check is signed:
  - Use the negate-and-compare of sw.
  - The most negative value (-2^(WIDTH-1)) is always out of range.
- Reset mid-WAIT_DONE: immediate return to IDLE; a late done from the core is ignored.

Optional Feature:
PRESS_SYNC_EN
- Defined: btn_press bits are raw debounced levels. Each bit goes through a 2-flop synchronizer and a rising-edge detector, which adds 2 cycles of latency to every button action. A level held high produces exactly one action.
- Undefined: btn_press bits are used directly as single-cycle pulses; no added latency.

Decomposition:
- Package cordic_seq_pkg holds:
  - state encoding: IDLE, ARMED, START_P, WAIT_DONE, SHOW (3 bits);
  - button index constants: BTN_LOAD=0, BTN_START=1, BTN_MODE=2, BTN_SHOW=3;
  - mode constants: MODE_ROT=0, MODE_VEC=1.
- One sub-module, btn_edge_sync: 4-bit synchronizer plus rising-edge detect. It is instantiated only under PRESS_SYNC_EN.

Test Plan:
- Reset mid-operation: reset pulse during WAIT_DONE -> all outputs 0 asynchronously; a done pulse arriving 5 cycles later leaves the state IDLE and the display at 0.
- Normal rotation run: sw=8192, LOAD, START, core asserts done after 20 cycles with x=6640, y=6891.
  - cordic_angle=8192, cordic_start high for exactly 1 cycle, busy high for 21 cycles.
  - disp_value=6640; after SHOW, disp_value=6891 and disp_sel=1.
- Range check: sw=12869, LOAD -> err=1, state stays IDLE. Then sw=-12868, LOAD -> err=0, ARMED, cordic_angle=-12868. Then sw=-32768, LOAD -> err=1, state IDLE.
- Timeout: LOAD 100, START, no done -> err=1 exactly TIMEOUT_CYCLES cycles after cordic_start; state IDLE.
- Priority and ignore rules:
  - btn_press=4'b0011 in ARMED -> operand re-latched, no cordic_start.
  - MODE during WAIT_DONE -> cordic_mode unchanged.
  - MODE in SHOW then START -> the new run uses the toggled mode.
- PRESS_SYNC_EN build: hold bit 1 high for 10 cycles in ARMED -> exactly one cordic_start, 3 cycles after the rising edge.
